// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the branch predictor update controller
package bp_pkg;

    localparam int PT_ADDR_MAX = 32;

    typedef logic [1:0] pt_ctr_t;

    localparam pt_ctr_t STRONG_NT = 2'd0;
    localparam pt_ctr_t WEAK_NT   = 2'd1;
    localparam pt_ctr_t WEAK_T    = 2'd2;
    localparam pt_ctr_t STRONG_T  = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_t;

    // Callers zero-extend the address in and truncate the result to their index width.
    function automatic logic [PT_ADDR_MAX-1:0] pt_index(input logic [PT_ADDR_MAX-1:0] addr,
                                                       input int iw);
        return addr & ((PT_ADDR_MAX'(1) << iw) - PT_ADDR_MAX'(1));
    endfunction

    function automatic pt_ctr_t sat_update(input pt_ctr_t c, input logic taken);
        if (taken)
            return (c == STRONG_T) ? STRONG_T : c + 2'd1;
        return (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_update_ctrl_if.sv
// rtl/branch_update_ctrl_if.sv - fetch, ALU and PT port signals of the update controller
interface branch_update_ctrl_if #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int INDEX_WIDTH   = 7
);
    logic                     i_IMEM_isbranch;
    logic [ADDRESS_WIDTH-1:0] i_IMEM_address;
    logic                     i_ALU_isbranch;
    logic [ADDRESS_WIDTH-1:0] i_ALU_pc;
    logic                     i_ALU_outcome;
    logic                     i_ALU_prediction;
    logic [ADDRESS_WIDTH-1:0] i_ALU_target;
    logic [1:0]               i_PT_rd_data;
    logic [INDEX_WIDTH-1:0]   o_PT_index;
    logic                     o_PT_wr_en;
    logic [1:0]               o_PT_wr_data;
    logic                     o_taken;
    logic                     o_valid;
    logic                     o_fetch_stall;
    logic                     o_flush;
    logic                     o_redirect_valid;
    logic [ADDRESS_WIDTH-1:0] o_redirect_pc;

    modport master (
        output i_IMEM_isbranch, i_IMEM_address, i_ALU_isbranch, i_ALU_pc, i_ALU_outcome,
               i_ALU_prediction, i_ALU_target, i_PT_rd_data,
        input  o_PT_index, o_PT_wr_en, o_PT_wr_data, o_taken, o_valid, o_fetch_stall,
               o_flush, o_redirect_valid, o_redirect_pc
    );

    modport slave (
        input  i_IMEM_isbranch, i_IMEM_address, i_ALU_isbranch, i_ALU_pc, i_ALU_outcome,
               i_ALU_prediction, i_ALU_target, i_PT_rd_data,
        output o_PT_index, o_PT_wr_en, o_PT_wr_data, o_taken, o_valid, o_fetch_stall,
               o_flush, o_redirect_valid, o_redirect_pc
    );

endinterface

// File: rtl/bp_update_fifo.sv
// rtl/bp_update_fifo.sv - resolved-branch update queue with simultaneous push/pop
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + (PW+1)'(1);
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - (PW+1)'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// rtl/branch_update_ctrl.sv - PT port arbiter, update queue drain and mispredict flush/redirect
module branch_update_ctrl
    import bp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 22,
    parameter int INDEX_WIDTH   = 7,
    parameter int QUEUE_DEPTH   = 4,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    branch_update_ctrl_if.slave  bus
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    fsm_state_t               r_state;
    fsm_state_t               w_state_nx;
    logic [CW-1:0]            r_flush_cnt;
    logic [CW-1:0]            w_flush_cnt_nx;
    logic                     r_redirect_valid;
    logic [ADDRESS_WIDTH-1:0] r_redirect_pc;

    logic [INDEX_WIDTH-1:0]   w_fetch_idx;
    logic [INDEX_WIDTH-1:0]   w_alu_idx;
    logic [INDEX_WIDTH:0]     w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_drain;
    logic                     w_lookup;
    logic                     w_mispredict;

    assign w_fetch_idx = INDEX_WIDTH'(pt_index(PT_ADDR_MAX'(bus.i_IMEM_address), INDEX_WIDTH));
    assign w_alu_idx   = INDEX_WIDTH'(pt_index(PT_ADDR_MAX'(bus.i_ALU_pc), INDEX_WIDTH));

    // Branches arriving while flushing belong to the squashed path.
    assign w_push       = bus.i_ALU_isbranch && (r_state == RUN);
    assign w_mispredict = w_push && (bus.i_ALU_outcome != bus.i_ALU_prediction);

    // A full queue takes the port outright so the ALU stage never has to stall.
    assign w_drain  = w_full || (!bus.i_IMEM_isbranch && !w_empty);
    assign w_lookup = !w_full && bus.i_IMEM_isbranch;

    bp_update_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (INDEX_WIDTH + 1)
    ) u_fifo (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_push    (w_push),
        .i_data    ({w_alu_idx, bus.i_ALU_outcome}),
        .i_pop     (w_drain),
        .o_data    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        bus.o_PT_index   = '0;
        bus.o_PT_wr_en   = 1'b0;
        bus.o_PT_wr_data = 2'b00;
        bus.o_taken      = 1'b0;
        bus.o_valid      = 1'b0;
        if (w_drain) begin
            bus.o_PT_index   = w_head[INDEX_WIDTH:1];
            bus.o_PT_wr_en   = 1'b1;
            bus.o_PT_wr_data = sat_update(bus.i_PT_rd_data, w_head[0]);
        end else if (w_lookup) begin
            bus.o_PT_index = w_fetch_idx;
            bus.o_taken    = bus.i_PT_rd_data[1];
            bus.o_valid    = 1'b1;
        end
    end

    assign bus.o_fetch_stall    = w_full;
    assign bus.o_flush          = (r_state == FLUSH);
    assign bus.o_redirect_valid = r_redirect_valid;
    assign bus.o_redirect_pc    = r_redirect_pc;

    always_comb begin
        w_state_nx     = r_state;
        w_flush_cnt_nx = r_flush_cnt;
        unique case (r_state)
            RUN: begin
                if (w_mispredict) begin
                    w_state_nx     = FLUSH;
                    w_flush_cnt_nx = CW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (r_flush_cnt == '0)
                    w_state_nx = RUN;
                else
                    w_flush_cnt_nx = r_flush_cnt - CW'(1);
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_flush_cnt <= w_flush_cnt_nx;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict)
                r_redirect_pc <= bus.i_ALU_outcome ? bus.i_ALU_target
                                                   : bus.i_ALU_pc + ADDRESS_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// tb/tb_branch_update_ctrl.sv - directed vector bench for branch_update_ctrl
module tb_branch_update_ctrl;

    logic i_Clk;
    logic i_Reset_n;
    int   total;
    int   bad;
    logic [1:0] pt_mem [128];

    branch_update_ctrl_if #(.ADDRESS_WIDTH(22), .INDEX_WIDTH(7)) bus ();

    branch_update_ctrl #(
        .ADDRESS_WIDTH (22),
        .INDEX_WIDTH   (7),
        .QUEUE_DEPTH   (4),
        .FLUSH_CYCLES  (2)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .bus       (bus)
    );

    assign bus.i_PT_rd_data = pt_mem[bus.o_PT_index];

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [21:0] addr;
        logic [1:0]  pt;
        logic [6:0]  exp_idx;
        logic        exp_taken;
    } lookup_vec_t;

    typedef struct {
        logic [21:0] pc;
        logic        taken;
        logic [1:0]  pt;
        logic [6:0]  exp_idx;
        logic [1:0]  exp_data;
    } update_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic       w;
        logic [6:0] i;
        logic [1:0] d;
        w = bus.o_PT_wr_en;
        i = bus.o_PT_index;
        d = bus.o_PT_wr_data;
        @(posedge i_Clk);
        if (w)
            pt_mem[i] = d;
        #1;
    endtask

    task automatic alu(input logic v, input logic [21:0] pc, input logic outc,
                       input logic pred, input logic [21:0] tgt);
        bus.i_ALU_isbranch   = v;
        bus.i_ALU_pc         = pc;
        bus.i_ALU_outcome    = outc;
        bus.i_ALU_prediction = pred;
        bus.i_ALU_target     = tgt;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_index"}, 32'(bus.o_PT_index), 0);
        chk({tag, "_wr_en"}, 32'(bus.o_PT_wr_en), 0);
        chk({tag, "_wr_data"}, 32'(bus.o_PT_wr_data), 0);
        chk({tag, "_taken"}, 32'(bus.o_taken), 0);
        chk({tag, "_valid"}, 32'(bus.o_valid), 0);
        chk({tag, "_stall"}, 32'(bus.o_fetch_stall), 0);
        chk({tag, "_flush"}, 32'(bus.o_flush), 0);
        chk({tag, "_rvalid"}, 32'(bus.o_redirect_valid), 0);
        chk({tag, "_rpc"}, 32'(bus.o_redirect_pc), 0);
    endtask

    function automatic logic [1:0] ref_sat(input logic [1:0] c, input logic t);
        if (t)
            return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    lookup_vec_t lv [5];
    update_vec_t uv [6];
    logic [21:0] fill_pc [5];
    logic        fill_t  [5];
    logic [1:0]  ref_pt  [128];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 128; i++) pt_mem[i] = 2'd0;
        lv[0] = '{22'h000005, 2'd2, 7'h05, 1'b1};
        lv[1] = '{22'h000085, 2'd1, 7'h05, 1'b0};
        lv[2] = '{22'h3FFFFF, 2'd3, 7'h7F, 1'b1};
        lv[3] = '{22'h000100, 2'd0, 7'h00, 1'b0};
        lv[4] = '{22'h00007F, 2'd2, 7'h7F, 1'b1};
        uv[0] = '{22'h000085, 1'b1, 2'd3, 7'h05, 2'd3};
        uv[1] = '{22'h000000, 1'b0, 2'd0, 7'h00, 2'd0};
        uv[2] = '{22'h000012, 1'b1, 2'd1, 7'h12, 2'd2};
        uv[3] = '{22'h000200, 1'b0, 2'd2, 7'h00, 2'd1};
        uv[4] = '{22'h00007F, 1'b1, 2'd2, 7'h7F, 2'd3};
        uv[5] = '{22'h000033, 1'b0, 2'd3, 7'h33, 2'd2};

        i_Reset_n = 1'b0;
        bus.i_IMEM_isbranch = 1'b0;
        bus.i_IMEM_address  = '0;
        alu(1'b0, 22'h0, 1'b0, 1'b0, 22'h0);
        tick();
        tick();
        chk_all_zero("reset");
        i_Reset_n = 1'b1;
        tick();

        // Fetch lookups: combinational, same cycle.
        for (int k = 0; k < 5; k++) begin
            pt_mem[lv[k].exp_idx] = lv[k].pt;
            bus.i_IMEM_isbranch = 1'b1;
            bus.i_IMEM_address  = lv[k].addr;
            #1;
            chk($sformatf("lk%0d_index", k), 32'(bus.o_PT_index), 32'(lv[k].exp_idx));
            chk($sformatf("lk%0d_valid", k), 32'(bus.o_valid), 1);
            chk($sformatf("lk%0d_taken", k), 32'(bus.o_taken), 32'(lv[k].exp_taken));
            chk($sformatf("lk%0d_wr_en", k), 32'(bus.o_PT_wr_en), 0);
            bus.i_IMEM_isbranch = 1'b0;
            tick();
        end

        // Single correctly-predicted updates drained on an idle port.
        for (int k = 0; k < 6; k++) begin
            pt_mem[uv[k].exp_idx] = uv[k].pt;
            alu(1'b1, uv[k].pc, uv[k].taken, uv[k].taken, 22'h0);
            #1;
            tick();
            alu(1'b0, 22'h0, 1'b0, 1'b0, 22'h0);
            #1;
            chk($sformatf("up%0d_wr_en", k), 32'(bus.o_PT_wr_en), 1);
            chk($sformatf("up%0d_index", k), 32'(bus.o_PT_index), 32'(uv[k].exp_idx));
            chk($sformatf("up%0d_data", k), 32'(bus.o_PT_wr_data), 32'(uv[k].exp_data));
            tick();
            chk($sformatf("up%0d_pt", k), 32'(pt_mem[uv[k].exp_idx]), 32'(uv[k].exp_data));
        end

        // Not-taken mispredict; a branch during the flush must be dropped.
        pt_mem[7'h10] = 2'd2;
        pt_mem[7'h20] = 2'd1;
        alu(1'b1, 22'h000010, 1'b0, 1'b1, 22'h000155);
        #1;
        chk("mp_pre_flush", 32'(bus.o_flush), 0);
        tick();
        alu(1'b1, 22'h000020, 1'b1, 1'b0, 22'h000077);
        #1;
        chk("mp_rvalid1", 32'(bus.o_redirect_valid), 1);
        chk("mp_rpc", 32'(bus.o_redirect_pc), 32'h11);
        chk("mp_flush1", 32'(bus.o_flush), 1);
        chk("mp_drain_en", 32'(bus.o_PT_wr_en), 1);
        chk("mp_drain_idx", 32'(bus.o_PT_index), 32'h10);
        chk("mp_drain_data", 32'(bus.o_PT_wr_data), 1);
        tick();
        alu(1'b0, 22'h0, 1'b0, 1'b0, 22'h0);
        #1;
        chk("mp_rvalid2", 32'(bus.o_redirect_valid), 0);
        chk("mp_flush2", 32'(bus.o_flush), 1);
        chk("mp_squashed", 32'(bus.o_PT_wr_en), 0);
        tick();
        chk("mp_flush3", 32'(bus.o_flush), 0);
        chk("mp_rvalid3", 32'(bus.o_redirect_valid), 0);
        chk("mp_pt10", 32'(pt_mem[7'h10]), 1);
        chk("mp_pt20", 32'(pt_mem[7'h20]), 1);

        // Fill the queue under continuous fetch lookups.
        fill_pc[0] = 22'h000040; fill_t[0] = 1'b1;
        fill_pc[1] = 22'h000041; fill_t[1] = 1'b0;
        fill_pc[2] = 22'h000042; fill_t[2] = 1'b1;
        fill_pc[3] = 22'h000040; fill_t[3] = 1'b1;
        fill_pc[4] = 22'h000043; fill_t[4] = 1'b0;
        pt_mem[7'h05] = 2'd2;
        pt_mem[7'h40] = 2'd1;
        pt_mem[7'h41] = 2'd0;
        pt_mem[7'h42] = 2'd3;
        pt_mem[7'h43] = 2'd2;
        for (int i = 0; i < 128; i++) ref_pt[i] = pt_mem[i];
        for (int k = 0; k < 5; k++)
            ref_pt[fill_pc[k][6:0]] = ref_sat(ref_pt[fill_pc[k][6:0]], fill_t[k]);
        bus.i_IMEM_isbranch = 1'b1;
        bus.i_IMEM_address  = 22'h000005;
        for (int k = 0; k < 4; k++) begin
            alu(1'b1, fill_pc[k], fill_t[k], fill_t[k], 22'h0);
            #1;
            chk($sformatf("fill%0d_valid", k), 32'(bus.o_valid), 1);
            chk($sformatf("fill%0d_taken", k), 32'(bus.o_taken), 1);
            chk($sformatf("fill%0d_stall", k), 32'(bus.o_fetch_stall), 0);
            tick();
        end
        alu(1'b1, fill_pc[4], fill_t[4], fill_t[4], 22'h0);
        #1;
        chk("full0_stall", 32'(bus.o_fetch_stall), 1);
        chk("full0_valid", 32'(bus.o_valid), 0);
        chk("full0_wr_en", 32'(bus.o_PT_wr_en), 1);
        chk("full0_index", 32'(bus.o_PT_index), 32'h40);
        tick();
        alu(1'b0, 22'h0, 1'b0, 1'b0, 22'h0);
        #1;
        chk("full1_stall", 32'(bus.o_fetch_stall), 1);
        chk("full1_index", 32'(bus.o_PT_index), 32'h41);
        tick();
        chk("after_full_stall", 32'(bus.o_fetch_stall), 0);
        chk("after_full_valid", 32'(bus.o_valid), 1);
        chk("after_full_wr_en", 32'(bus.o_PT_wr_en), 0);
        bus.i_IMEM_isbranch = 1'b0;
        #1;
        chk("drain2_index", 32'(bus.o_PT_index), 32'h42);
        tick();
        chk("drain3_index", 32'(bus.o_PT_index), 32'h40);
        tick();
        chk("drain4_index", 32'(bus.o_PT_index), 32'h43);
        chk("drain4_wr_en", 32'(bus.o_PT_wr_en), 1);
        tick();
        chk("drain_done", 32'(bus.o_PT_wr_en), 0);
        for (int i = 'h40; i <= 'h43; i++)
            chk($sformatf("fill_pt%0h", i), 32'(pt_mem[i]), 32'(ref_pt[i]));

        // Taken mispredict to the top address, then pc+1 wrapping to zero.
        alu(1'b1, 22'h000001, 1'b1, 1'b0, 22'h3FFFFF);
        #1;
        tick();
        alu(1'b0, 22'h0, 1'b0, 1'b0, 22'h0);
        #1;
        chk("wrap_t_rvalid", 32'(bus.o_redirect_valid), 1);
        chk("wrap_t_rpc", 32'(bus.o_redirect_pc), 32'h3FFFFF);
        tick();
        tick();
        chk("wrap_run", 32'(bus.o_flush), 0);
        alu(1'b1, 22'h3FFFFF, 1'b0, 1'b1, 22'h000123);
        #1;
        tick();
        alu(1'b0, 22'h0, 1'b0, 1'b0, 22'h0);
        #1;
        chk("wrap_nt_rvalid", 32'(bus.o_redirect_valid), 1);
        chk("wrap_nt_rpc", 32'(bus.o_redirect_pc), 32'h0);
        tick();
        tick();
        tick();

        // Async reset while flushing with three entries queued.
        for (int i = 'h50; i <= 'h52; i++) pt_mem[i] = 2'd1;
        bus.i_IMEM_isbranch = 1'b1;
        bus.i_IMEM_address  = 22'h000005;
        alu(1'b1, 22'h000050, 1'b1, 1'b1, 22'h0);
        #1;
        tick();
        alu(1'b1, 22'h000051, 1'b1, 1'b1, 22'h0);
        #1;
        tick();
        alu(1'b1, 22'h000052, 1'b0, 1'b1, 22'h0);
        #1;
        tick();
        chk("rst_pre_flush", 32'(bus.o_flush), 1);
        chk("rst_pre_wr_en", 32'(bus.o_PT_wr_en), 0);
        #2;
        i_Reset_n = 1'b0;
        bus.i_IMEM_isbranch = 1'b0;
        alu(1'b0, 22'h0, 1'b0, 1'b0, 22'h0);
        #1;
        chk_all_zero("rst_async");
        tick();
        chk_all_zero("rst_hold");
        i_Reset_n = 1'b1;
        #1;
        tick();
        chk("rst_post_wr_en", 32'(bus.o_PT_wr_en), 0);
        chk("rst_post_flush", 32'(bus.o_flush), 0);
        tick();
        for (int i = 'h50; i <= 'h52; i++)
            chk($sformatf("rst_pt%0h", i), 32'(pt_mem[i]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
